sega_joy_scanner: RTL and testbench

Parametrised multi-port Sega joystick scanner. It drives the shared P7 select line through the Mega Drive 6-button select sequence and auto-detects Master System, 3-button and 6-button pads per port. Results are published atomically once per scan. It sits between the DB9 pins and the core input mapping in each arcade top level, and uses an internal clock-enable prescaler rather than a video sync edge.

---
 rtl/sega_joy_scanner.sv | 121 ++++++++++++
 tb/tb_sega_joy_scanner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sega_joy_scanner.sv
// sega_joy_scanner: multi-port Sega DB9 pad scanner (Master System / 3-button / 6-button auto-detect)
// Ports: clk_sys/RESET (sync, active high); joy_*_i raw active-low DB9 pins per port;
// joy_p7_o shared select; joy_o {M,X,Y,Z,S,A,C,B,R,L,D,U} per port (active low);
// md_o/six_o pad type flags; scan_done_o one-cycle pulse on each commit.
// Optional: define JOY_DEBOUNCE_EN to commit joy_o only after two identical scans.
module sega_joy_scanner #(
  parameter int NUM_PORTS  = 2,
  parameter int STEP_DIV   = 1536,
  parameter int IDLE_STEPS = 248
) (
  input  logic                      clk_sys,
  input  logic                      RESET,
  input  logic [NUM_PORTS-1:0]      joy_up_i,
  input  logic [NUM_PORTS-1:0]      joy_down_i,
  input  logic [NUM_PORTS-1:0]      joy_left_i,
  input  logic [NUM_PORTS-1:0]      joy_right_i,
  input  logic [NUM_PORTS-1:0]      joy_p6_i,
  input  logic [NUM_PORTS-1:0]      joy_p9_i,
  output logic                      joy_p7_o,
  output logic [12*NUM_PORTS-1:0]   joy_o,
  output logic [NUM_PORTS-1:0]      md_o,
  output logic [NUM_PORTS-1:0]      six_o,
  output logic                      scan_done_o
);
  localparam int PW = $clog2(STEP_DIV);
  localparam int SW = $clog2(8 + IDLE_STEPS);
  localparam logic [PW-1:0] P_MAX = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0] S_MAX = SW'(7 + IDLE_STEPS);
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] step_q, step_d;
  logic p7_q, p7_d, done_q, done_d, tick;
  logic [NUM_PORTS-1:0] md_c_q, md_c_d, six_c_q, six_c_d, md_q, md_d, six_q, six_d;
  logic [NUM_PORTS-1:0][11:0] shadow_q, shadow_d, joy_q, joy_d;
`ifdef JOY_DEBOUNCE_EN
  logic [NUM_PORTS-1:0][11:0] prev_q, prev_d;
`endif
  assign tick = presc_q == P_MAX;
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    step_d = step_q;
    p7_d = p7_q;
    shadow_d = shadow_q;
    md_c_d = md_c_q;
    six_c_d = six_c_q;
    joy_d = joy_q;
    md_d = md_q;
    six_d = six_q;
    done_d = 1'b0;
`ifdef JOY_DEBOUNCE_EN
    prev_d = prev_q;
`endif
    if (tick) begin
      step_d = (step_q == S_MAX) ? '0 : step_q + 1'b1;
      // Active sequence alternates low/high starting low; idle steps hold select high
      p7_d = (step_q < SW'(8)) ? step_q[0] : 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (step_q == SW'(2)) begin
          shadow_d[i][5:0] = {joy_p9_i[i], joy_p6_i[i], joy_right_i[i], joy_left_i[i], joy_down_i[i], joy_up_i[i]};
          six_c_d[i] = 1'b0;
        end else if (step_q == SW'(3)) begin
          // An MD pad forces Left/Right low while select is low; an SMS pad cannot
          md_c_d[i] = ~(joy_right_i[i] | joy_left_i[i]);
          shadow_d[i][7:4] = md_c_d[i] ? {joy_p9_i[i], joy_p6_i[i], shadow_q[i][5:4]}
                                       : {2'b11, joy_p9_i[i], joy_p6_i[i]};
        end else if (step_q == SW'(5)) begin
          // Third low phase: a 6-button pad pulls all four directions low
          if (~|{joy_right_i[i], joy_left_i[i], joy_down_i[i], joy_up_i[i]}) six_c_d[i] = 1'b1;
        end else if (step_q == SW'(6)) begin
          shadow_d[i][11:8] = six_c_q[i] ? {joy_right_i[i], joy_left_i[i], joy_down_i[i], joy_up_i[i]} : 4'hF;
        end
      end
      if (step_q == SW'(7)) begin
        md_d = md_c_q;
        six_d = six_c_q;
        done_d = 1'b1;
`ifdef JOY_DEBOUNCE_EN
        prev_d = shadow_q;
        for (int i = 0; i < NUM_PORTS; i++) joy_d[i] = (shadow_q[i] == prev_q[i]) ? shadow_q[i] : joy_q[i];
`else
        joy_d = shadow_q;
`endif
      end
    end
  end
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      presc_q <= '0;
      step_q <= '0;
      p7_q <= 1'b1;
      done_q <= 1'b0;
      md_c_q <= '0;
      six_c_q <= '0;
      md_q <= '0;
      six_q <= '0;
      shadow_q <= '1;
      joy_q <= '1;
`ifdef JOY_DEBOUNCE_EN
      prev_q <= '1;
`endif
    end else begin
      presc_q <= presc_d;
      step_q <= step_d;
      p7_q <= p7_d;
      done_q <= done_d;
      md_c_q <= md_c_d;
      six_c_q <= six_c_d;
      md_q <= md_d;
      six_q <= six_d;
      shadow_q <= shadow_d;
      joy_q <= joy_d;
`ifdef JOY_DEBOUNCE_EN
      prev_q <= prev_d;
`endif
    end
  end
  assign joy_p7_o = p7_q;
  assign joy_o = joy_q;
  assign md_o = md_q;
  assign six_o = six_q;
  assign scan_done_o = done_q;
endmodule

// File: tb/tb_sega_joy_scanner.sv
// tb_sega_joy_scanner: directed bench for sega_joy_scanner with behavioural DB9 pad models
module tb_sega_joy_scanner;
  localparam int NP = 2, SD = 4, IS = 2;
  localparam int UNPLUG = 0, MS = 1, MD3 = 2, MD6 = 3;
`ifdef JOY_DEBOUNCE_EN
  localparam int NW = 3;
`else
  localparam int NW = 2;
`endif
  logic clk_sys = 1'b0;
  logic RESET = 1'b1;
  logic [NP-1:0] joy_up_i, joy_down_i, joy_left_i, joy_right_i, joy_p6_i, joy_p9_i;
  logic joy_p7_o, scan_done_o;
  logic [12*NP-1:0] joy_o;
  logic [NP-1:0] md_o, six_o;
  logic [11:0] btn [NP];
  int mode [NP];
  logic [5:0] pins [NP];
  int low_cnt = 0, hi_cnt = 0;
  logic p7_prev = 1'b1;
  int total = 0, fails = 0;
  logic [9:0] pat = 10'b1110101010;

  sega_joy_scanner #(.NUM_PORTS(NP), .STEP_DIV(SD), .IDLE_STEPS(IS)) dut (
    .clk_sys(clk_sys), .RESET(RESET),
    .joy_up_i(joy_up_i), .joy_down_i(joy_down_i), .joy_left_i(joy_left_i),
    .joy_right_i(joy_right_i), .joy_p6_i(joy_p6_i), .joy_p9_i(joy_p9_i),
    .joy_p7_o(joy_p7_o), .joy_o(joy_o), .md_o(md_o), .six_o(six_o),
    .scan_done_o(scan_done_o)
  );

  always #5 clk_sys = ~clk_sys;

  // 6-button pad counts select falling edges; a long high period resets its counter
  always @(negedge clk_sys) begin
    if (joy_p7_o === 1'b1) begin
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt > 6) low_cnt <= 0;
    end else begin
      hi_cnt <= 0;
      if (p7_prev) low_cnt <= low_cnt + 1;
    end
    p7_prev <= joy_p7_o;
  end

  // pins = {p9,p6,R,L,D,U}; btn uses the output layout {M,X,Y,Z,S,A,C,B,R,L,D,U}
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      pins[p] = 6'h3F;
      if (mode[p] == MS) pins[p] = btn[p][5:0];
      else if (mode[p] >= MD3) begin
        if (joy_p7_o) pins[p] = (mode[p] == MD6 && low_cnt == 3) ? {btn[p][5:4], btn[p][11:8]} : btn[p][5:0];
        else pins[p] = (mode[p] == MD6 && low_cnt == 3) ? {btn[p][7:6], 4'h0} :
                       (mode[p] == MD6 && low_cnt == 4) ? {btn[p][7:6], 4'hF} :
                       {btn[p][7:6], 2'b00, btn[p][1:0]};
      end
      joy_up_i[p] = pins[p][0];
      joy_down_i[p] = pins[p][1];
      joy_left_i[p] = pins[p][2];
      joy_right_i[p] = pins[p][3];
      joy_p6_i[p] = pins[p][4];
      joy_p9_i[p] = pins[p][5];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!scan_done_o && n < 100);
    chk("done_seen", scan_done_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int p = 0; p < NP; p++) begin
      mode[p] = UNPLUG;
      btn[p] = 12'hFFF;
    end
    RESET = 1'b1;
    repeat (5) cyc();
    chk("rst_p7", joy_p7_o, 1);
    chk("rst_joy", joy_o, 24'hFFFFFF);
    chk("rst_md", md_o, 0);
    chk("rst_six", six_o, 0);
    chk("rst_done", scan_done_o, 0);
    RESET = 1'b0;
    // Idle: select pattern per step and done pulses every 40 cycles
    for (int k = 1; k <= 80; k++) begin
      cyc();
      if (k % 4 == 2) chk("idle_p7", joy_p7_o, (k < 4) ? 1 : pat[((k / 4) - 1) % 10]);
      chk("idle_done", scan_done_o, (k == 32 || k == 72));
    end
    chk("idle_joy", joy_o, 24'hFFFFFF);
    chk("idle_md", md_o, 0);
    chk("idle_six", six_o, 0);
    // 3-button pad on port 0, Start and A pressed
    mode[0] = MD3;
    btn[0] = 12'hF3F;
    repeat (NW) wait_done();
    chk("md3_joy0", joy_o[11:0], 12'hF3F);
    chk("md3_md", md_o, 2'b01);
    chk("md3_six", six_o, 2'b00);
    chk("md3_joy1", joy_o[23:12], 12'hFFF);
    // 6-button pad on port 1, X pressed
    mode[1] = MD6;
    btn[1] = 12'hBFF;
    repeat (NW) wait_done();
    chk("md6_mxyz", joy_o[23:20], 4'hB);
    chk("md6_joy1", joy_o[23:12], 12'hBFF);
    chk("md6_six", six_o, 2'b10);
    chk("md6_md", md_o, 2'b11);
    chk("md6_joy0", joy_o[11:0], 12'hF3F);
    // Master System pad on port 0, button 1 pressed
    mode[0] = MS;
    btn[0] = 12'hFEF;
    repeat (NW) wait_done();
    chk("ms_joy0", joy_o[11:0], 12'hFEF);
    chk("ms_md", md_o, 2'b10);
    wait_done();
    chk("ms_joy0_again", joy_o[11:0], 12'hFEF);
    chk("ms_six", six_o, 2'b10);
    // Reset pulsed while step 4 is active
    wait_done();
    repeat (26) cyc();
    RESET = 1'b1;
    cyc();
    chk("mid_rst_p7", joy_p7_o, 1);
    chk("mid_rst_joy", joy_o, 24'hFFFFFF);
    chk("mid_rst_md", md_o, 0);
    chk("mid_rst_six", six_o, 0);
    chk("mid_rst_done", scan_done_o, 0);
    repeat (3) cyc();
    RESET = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!scan_done_o && n < 100);
    chk("rst_latency", n, 32);
`ifdef JOY_DEBOUNCE_EN
    chk("post_rst_joy", joy_o, 24'hFFFFFF);
`else
    chk("post_rst_joy", joy_o, 24'hBFFFEF);
`endif
    chk("post_rst_md", md_o, 2'b10);
    chk("post_rst_six", six_o, 2'b10);
    // Both ports unplugged
    mode[0] = UNPLUG;
    mode[1] = UNPLUG;
    repeat (NW) wait_done();
    chk("unplug_joy", joy_o, 24'hFFFFFF);
    chk("unplug_md", md_o, 0);
    chk("unplug_six", six_o, 0);
`ifdef JOY_DEBOUNCE_EN
    // Single-scan glitch on Up must not reach joy_o; a held press must
    mode[0] = MS;
    btn[0] = 12'hFFE;
    wait_done();
    chk("deb_glitch1", joy_o[11:0], 12'hFFF);
    btn[0] = 12'hFFF;
    wait_done();
    chk("deb_glitch2", joy_o[11:0], 12'hFFF);
    btn[0] = 12'hFFE;
    wait_done();
    chk("deb_hold1", joy_o[11:0], 12'hFFF);
    wait_done();
    chk("deb_hold2", joy_o[11:0], 12'hFFE);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
